// File: rtl/game_round_sequencer.sv
// Round controller for one sprite: loads start position/speed, runs motion until a hit or miss, then pauses.
// Optional GAME_ROUND_AUTO_RESTART_EN: after the pause the next round starts without a launch edge.
module game_round_sequencer #(
  parameter int w_x             = 10,
  parameter int w_y             = 9,
  parameter int DX_WIDTH        = 2,
  parameter int DY_WIDTH        = 2,
  parameter int START_X         = 0,
  parameter int START_Y         = 100,
  parameter int START_DX        = 1,
  parameter int START_DY        = 1,
  parameter int END_WAIT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                launch,
  input  logic                collision,
  input  logic                out_of_screen,
  output logic                sprite_write_xy,
  output logic                sprite_write_dxy,
  output logic [w_x-1:0]      sprite_write_x,
  output logic [w_y-1:0]      sprite_write_y,
  output logic [DX_WIDTH-1:0] sprite_write_dx,
  output logic [DY_WIDTH-1:0] sprite_write_dy,
  output logic                sprite_enable_update,
  output logic                game_won,
  output logic                end_of_game,
  output logic                round_active,
  output logic [7:0]          score
);

  typedef enum logic [1:0] {IDLE, INIT, PLAY, END_WAIT} state_t;

  localparam int CNT_W = $clog2(END_WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]    WAIT_LOAD = CNT_W'(END_WAIT_CYCLES - 1);
  localparam logic [w_x-1:0]      X0        = w_x'(START_X);
  localparam logic [w_y-1:0]      Y0        = w_y'(START_Y);
  localparam logic [DX_WIDTH-1:0] DX_POS    = DX_WIDTH'(START_DX);
  localparam logic [DX_WIDTH-1:0] DX_NEG    = DX_WIDTH'(-START_DX);
  localparam logic [DY_WIDTH-1:0] DY0       = DY_WIDTH'(START_DY);

  state_t           state;
  logic             launch_prev;
  logic             dir_neg;
  logic [CNT_W-1:0] wait_cnt;
  logic             launch_rise;

  assign launch_rise = launch & ~launch_prev;

  // Outputs are registered alongside the state so they always match the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      launch_prev          <= 1'b0;
      dir_neg              <= 1'b0;
      wait_cnt             <= '0;
      sprite_write_xy      <= 1'b0;
      sprite_write_dxy     <= 1'b0;
      sprite_write_x       <= '0;
      sprite_write_y       <= '0;
      sprite_write_dx      <= '0;
      sprite_write_dy      <= '0;
      sprite_enable_update <= 1'b0;
      game_won             <= 1'b0;
      end_of_game          <= 1'b0;
      round_active         <= 1'b0;
      score                <= '0;
    end else begin
      launch_prev      <= launch;
      sprite_write_xy  <= 1'b0;
      sprite_write_dxy <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_rise) begin
            state            <= INIT;
            sprite_write_xy  <= 1'b1;
            sprite_write_dxy <= 1'b1;
            sprite_write_x   <= X0;
            sprite_write_y   <= Y0;
            sprite_write_dx  <= dir_neg ? DX_NEG : DX_POS;
            sprite_write_dy  <= DY0;
            round_active     <= 1'b1;
          end
        end
        INIT: begin
          state                <= PLAY;
          dir_neg              <= ~dir_neg;
          game_won             <= 1'b0;
          sprite_enable_update <= 1'b1;
        end
        PLAY: begin
          // A collision takes priority over a simultaneous miss.
          if (collision || out_of_screen) begin
            state                <= END_WAIT;
            wait_cnt             <= WAIT_LOAD;
            sprite_enable_update <= 1'b0;
            round_active         <= 1'b0;
            end_of_game          <= 1'b1;
            game_won             <= collision;
            if (collision && score != 8'hFF)
              score <= score + 8'd1;
          end
        end
        END_WAIT: begin
          if (wait_cnt == '0) begin
            end_of_game <= 1'b0;
`ifdef GAME_ROUND_AUTO_RESTART_EN
            state            <= INIT;
            sprite_write_xy  <= 1'b1;
            sprite_write_dxy <= 1'b1;
            sprite_write_x   <= X0;
            sprite_write_y   <= Y0;
            sprite_write_dx  <= dir_neg ? DX_NEG : DX_POS;
            sprite_write_dy  <= DY0;
            round_active     <= 1'b1;
`else
            state <= IDLE;
`endif
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed self-checking bench for game_round_sequencer with a 4-cycle end pause.
module tb_game_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       launch, collision, out_of_screen;
  logic       sprite_write_xy, sprite_write_dxy;
  logic [9:0] sprite_write_x;
  logic [8:0] sprite_write_y;
  logic [1:0] sprite_write_dx, sprite_write_dy;
  logic       sprite_enable_update, game_won, end_of_game, round_active;
  logic [7:0] score;

  int checkCount = 0;
  int failCount  = 0;

  game_round_sequencer #(.END_WAIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .launch(launch), .collision(collision),
    .out_of_screen(out_of_screen),
    .sprite_write_xy(sprite_write_xy), .sprite_write_dxy(sprite_write_dxy),
    .sprite_write_x(sprite_write_x), .sprite_write_y(sprite_write_y),
    .sprite_write_dx(sprite_write_dx), .sprite_write_dy(sprite_write_dy),
    .sprite_enable_update(sprite_enable_update), .game_won(game_won),
    .end_of_game(end_of_game), .round_active(round_active), .score(score)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs, then let one rising edge pass and settle 1ns before any check.
  task automatic applyStimulus(input logic l, input logic c, input logic o);
    launch = l; collision = c; out_of_screen = o;
    @(posedge clk); #1;
  endtask

  task automatic hitRound();
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    repeat (4) applyStimulus(0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; launch = 1'b0; collision = 1'b0; out_of_screen = 1'b0;
    #12;
    checkOutput("rst_state", {sprite_write_xy, sprite_write_dxy, sprite_enable_update,
                              game_won, end_of_game, round_active}, 0);
    checkOutput("rst_score", score, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 1, 1);
    checkOutput("idle_ignores_hit", {end_of_game, score}, 0);

    // Round 1: launch edge -> one INIT cycle with start values, then motion, then a hit.
    applyStimulus(1, 0, 0);
    checkOutput("r1_strobes", {sprite_write_xy, sprite_write_dxy}, 2'b11);
    checkOutput("r1_x", sprite_write_x, 0);
    checkOutput("r1_y", sprite_write_y, 100);
    checkOutput("r1_dx", sprite_write_dx, 2'b01);
    checkOutput("r1_dy", sprite_write_dy, 2'b01);
    checkOutput("r1_init_en", {sprite_enable_update, round_active}, 2'b01);
    applyStimulus(1, 0, 0);
    checkOutput("r1_play", {sprite_write_xy, sprite_write_dxy, sprite_enable_update, round_active}, 4'b0011);
    applyStimulus(0, 0, 0);
    checkOutput("r1_play_hold", sprite_enable_update, 1);
    applyStimulus(0, 1, 0);
    checkOutput("r1_end", {end_of_game, game_won, sprite_enable_update, round_active}, 4'b1100);
    checkOutput("r1_score", score, 1);
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("r1_wait_last", end_of_game, 1);
    applyStimulus(0, 0, 0);
    checkOutput("r1_idle", {end_of_game, round_active, game_won}, 3'b001);

    // Round 2: negative launch direction, ended by a miss.
    applyStimulus(1, 0, 0);
    checkOutput("r2_dx", sprite_write_dx, 2'b11);
    checkOutput("r2_won_kept", game_won, 1);
    applyStimulus(0, 0, 0);
    checkOutput("r2_won_clr", game_won, 0);
    applyStimulus(0, 0, 1);
    checkOutput("r2_miss", {end_of_game, game_won}, 2'b10);
    checkOutput("r2_score", score, 1);

    // Launch rises during the pause and is held: no new round.
    repeat (4) applyStimulus(1, 0, 0);
    checkOutput("r2_idle", end_of_game, 0);
    repeat (3) applyStimulus(1, 0, 0);
    checkOutput("held_launch", {round_active, sprite_write_xy}, 0);

    // Round 3: back to positive direction, simultaneous hit and miss counts as a hit.
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("r3_dx", sprite_write_dx, 2'b01);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    checkOutput("r3_both", {game_won, score}, {1'b1, 8'd2});
    repeat (4) applyStimulus(0, 0, 0);

    // Round 4: asynchronous reset in the middle of PLAY.
    applyStimulus(1, 0, 0);
    checkOutput("r4_dx", sprite_write_dx, 2'b11);
    applyStimulus(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst", {sprite_enable_update, round_active, game_won, end_of_game,
                              sprite_write_xy, score}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Direction restarts positive after reset; then drive the score into saturation.
    applyStimulus(1, 0, 0);
    checkOutput("post_rst_dx", sprite_write_dx, 2'b01);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("post_rst_score", score, 1);
    repeat (4) applyStimulus(0, 0, 0);
    for (int i = 0; i < 254; i++) hitRound();
    checkOutput("score_255", score, 255);
    hitRound();
    checkOutput("score_sat", score, 255);
    checkOutput("sat_won", game_won, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
